adc_spi_scanner: RTL and testbench
==================================

# adc_spi_scanner

Parametrised SPI master for multi-channel successive-approximation ADCs (MCP300x family and similar). Issues single conversions on request or scans channels 0..CHANNELS-1 round-robin. Returns each result with its channel tag and a one-cycle valid strobe. Sits between the ADC pins (`sclkAdc`/`doutAdc`/`dinAdc`/`ncsAdc`) and the sample path that feeds the Pi-facing SPI slave.

## Interface
**Parameters**
- `CHANNELS`, 4: channels scanned; must satisfy 1 ≤ CHANNELS ≤ 2**CH_ADDR_W.
- `CH_ADDR_W`, 3: channel-address bits sent per frame.
- `RES_BITS`, 10: conversion result width.
- `CLK_DIV`, 4: clk cycles per SCLK half-period (H); minimum 2.
- `CS_IDLE`, 8: minimum clk cycles `ncsAdc` stays high between frames.
- `DIFF`, 0: 1 selects pseudo-differential mode (SGL bit sent as 0).

**Ports**
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-conversion request, sampled in IDLE.
- `scan`  in  1  level; while high, run continuous round-robin scanning.
- `chan_sel`  in  CH_ADDR_W  channel for single conversion.
- `sclkAdc`  out  1  SPI clock, idle low (mode 0).
- `doutAdc`  out  1  command bits to ADC.
- `dinAdc`  in  1  result bits from ADC.
- `ncsAdc`  out  1  ADC chip select, active low.
- `sample`  out  RES_BITS  last completed result.
- `sample_ch`  out  CH_ADDR_W  channel of `sample`.
- `valid`  out  1  one-cycle strobe when `sample` updates.
- `busy`  out  1  high from frame start through end of CS_IDLE gap.

## Operation
- States: IDLE → FRAME → GAP → IDLE.
- IDLE: `scan` high starts a frame on the next scan channel (has priority over `start`). Otherwise `start` high with `chan_sel` < CHANNELS starts a frame on `chan_sel`. A `start` with `chan_sel` ≥ CHANNELS is dropped.
- Frame has N = 4 + CH_ADDR_W + RES_BITS SCLK periods (default 17).
  - Command bits MSB-first: START=1, SGL=~DIFF, then channel address.
  - Then 2 don't-care SCLKs (sample + null bit; `doutAdc` = 0).
  - Then RES_BITS result bits MSB-first from `dinAdc`.
- `doutAdc` changes only while `sclkAdc` is low. `dinAdc` is shifted in on the clk edge where `sclkAdc` goes high.
- Scan pointer increments after each scan frame, wraps CHANNELS-1 → 0. Reset sets it to 0. Single conversions do not move it.
- `scan` dropping mid-frame: the current frame completes and is reported; no further scan frames.
- `start` while busy: ignored, not queued.
- GAP: `ncsAdc` high, `sclkAdc` low, for CS_IDLE cycles, then IDLE.
- Reset outputs: `ncsAdc`=1, `sclkAdc`=0, `doutAdc`=0, `sample`=0, `sample_ch`=0, `valid`=0, `busy`=0. State is IDLE.
- Reset asserted mid-frame: next edge returns to the reset values. No `valid`; partial data is discarded.

## Timing
- Cycle 0: IDLE edge that accepts the request.
- Cycle 1: `ncsAdc` low, `busy` high, START bit on `doutAdc`.
- SCLK k (k = 0..N-1):
  - rises at cycle 1+(2k+1)H;
  - falls at cycle 1+(2k+2)H.
- Cycle 1+2NH: `ncsAdc` high, `sample`/`sample_ch` updated, `valid` high for exactly this cycle.
- `busy` falls at cycle 1+2NH+CS_IDLE; a new frame can be accepted that same cycle.
- Defaults: frame 137 clk cycles including cycle 0; scan period per channel 144 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `adc_pkg`: state enum (IDLE, FRAME, GAP); frame-length and field-offset constants as functions of the parameters.
- One sub-module, `adc_sclk_gen`: a CLK_DIV half-period tick counter with enable. The counter restarts on enable; it drives SCLK toggling and bit-count advance.
- Top holds the FSM, SCLK-period counter, command shift register, result shift register and scan pointer.

## Test plan
- Single conversion, chan_sel=5, DIFF=0; ADC model returns 0x2A5.
  - `doutAdc` = 1,1,1,0,1 on the first 5 SCLKs.
  - `valid` at cycle 137 with `sample`=0x2A5, `sample_ch`=5.
- `scan` held high for 5 frames, model returns 0x100+ch.
  - Results appear on channels 0,1,2,3,0 with matching values.
  - `ncsAdc` high ≥ 8 cycles between frames.
- `start` with `chan_sel`=6, CHANNELS=4 → no frame; `ncsAdc` stays 1, `busy` stays 0.
- `start` pulsed during an active frame → ignored; exactly one `valid`.
- Reset asserted at SCLK 9 → next edge `ncsAdc`=1, `sclkAdc`=0, `sample` unchanged from 0, no `valid`.
- DIFF=1, RES_BITS=12, CLK_DIV=2, chan_sel=2, model returns 0xFFF.
  - SGL bit = 0; N=19.
  - `valid` at cycle 77 with `sample`=0xFFF.

Source files
------------

// File: rtl/adc_spi_scanner_pkg.sv
// Shared types and frame-geometry helpers for the MCP300x-style ADC scanner.
// The frame layout is START, SGL/DIFF, channel address, two null clocks, then the result.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } adc_state_e;

  localparam int PRE_BITS  = 2;
  localparam int NULL_BITS = 2;

  function automatic int cmd_bits(input int ch_addr_w);
    return PRE_BITS + ch_addr_w;
  endfunction

  function automatic int result_offset(input int ch_addr_w);
    return PRE_BITS + ch_addr_w + NULL_BITS;
  endfunction

  function automatic int frame_bits(input int ch_addr_w, input int res_bits);
    return result_offset(ch_addr_w) + res_bits;
  endfunction

  // Width of a counter that must hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/adc_spi_scanner_if.sv
// ADC-side SPI pins; the scanner drives the master view, an ADC (or its model) the slave view.
interface adc_spi_scanner_if;

  logic sclkAdc;
  logic doutAdc;
  logic dinAdc;
  logic ncsAdc;

  modport master (
    output sclkAdc,
    output doutAdc,
    output ncsAdc,
    input  dinAdc
  );

  modport slave (
    input  sclkAdc,
    input  doutAdc,
    input  ncsAdc,
    output dinAdc
  );

endinterface

// File: rtl/adc_spi_scanner_sclk_gen.sv
// Half-period tick generator: one tick every CLK_DIV cycles while enabled.
// Dropping the enable restarts the count so every frame starts phase-aligned.
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: hold at zero while disabled, wrap at the end of a half period
  always_comb begin
    cnt_d = '0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_spi_scanner.sv
// SPI master for multi-channel SAR ADCs: single conversions on request or round-robin scanning.
// Each result leaves with its channel tag and a one-cycle valid strobe.
module adc_spi_scanner
  import adc_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CH_ADDR_W = 3,
  parameter int RES_BITS  = 10,
  parameter int CLK_DIV   = 4,
  parameter int CS_IDLE   = 8,
  parameter int DIFF      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 scan,
  input  logic [CH_ADDR_W-1:0] chan_sel,
  adc_spi_scanner_if.master    spi,
  output logic [RES_BITS-1:0]  sample,
  output logic [CH_ADDR_W-1:0] sample_ch,
  output logic                 valid,
  output logic                 busy
);

  localparam int N     = frame_bits(CH_ADDR_W, RES_BITS);
  localparam int CMD_W = cmd_bits(CH_ADDR_W);
  localparam int BIT_W = cnt_width(N - 1);
  localparam int GAP_W = cnt_width(CS_IDLE - 1);

  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(N - 1);
  localparam logic [GAP_W-1:0]     LAST_GAP = GAP_W'(CS_IDLE - 1);
  localparam logic [CH_ADDR_W:0]   CH_LIMIT = (CH_ADDR_W + 1)'(CHANNELS);
  localparam logic [CH_ADDR_W-1:0] LAST_CH  = CH_ADDR_W'(CHANNELS - 1);
  localparam logic                 SGL_BIT  = (DIFF == 0) ? 1'b1 : 1'b0;

  adc_state_e           state_q;
  logic                 sclk_q;
  logic                 dout_q;
  logic                 ncs_q;
  logic [CMD_W-1:0]     cmd_q;
  logic [RES_BITS-1:0]  res_q;
  logic [BIT_W-1:0]     bit_q;
  logic [GAP_W-1:0]     gap_q;
  logic [CH_ADDR_W-1:0] ptr_q;
  logic [CH_ADDR_W-1:0] cur_ch_q;
  logic                 cur_scan_q;
  logic [RES_BITS-1:0]  sample_q;
  logic [CH_ADDR_W-1:0] sample_ch_q;
  logic                 valid_q;
  logic                 busy_q;

  logic                 req_go_d;
  logic                 req_scan_d;
  logic [CH_ADDR_W-1:0] req_ch_d;
  logic [CMD_W-1:0]     cmd_word_d;
  logic                 launch_d;
  logic                 tick;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == FRAME),
    .tick_o (tick)
  );

  // request arbitration: scanning wins, out-of-range single requests are dropped;
  // the last gap cycle accepts requests too so back-to-back scan frames keep CS_IDLE exact
  always_comb begin
    req_go_d   = 1'b0;
    req_scan_d = 1'b0;
    req_ch_d   = ptr_q;
    if (scan) begin
      req_go_d   = 1'b1;
      req_scan_d = 1'b1;
      req_ch_d   = ptr_q;
    end else if (start && ({1'b0, chan_sel} < CH_LIMIT)) begin
      req_go_d = 1'b1;
      req_ch_d = chan_sel;
    end else begin
      req_go_d = 1'b0;
    end
    cmd_word_d = {1'b1, SGL_BIT, req_ch_d};
    launch_d   = req_go_d && ((state_q == IDLE) || ((state_q == GAP) && (gap_q == LAST_GAP)));
  end

  // frame sequencer; every pin and result output is driven from here
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      dout_q      <= 1'b0;
      ncs_q       <= 1'b1;
      cmd_q       <= '0;
      res_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      ptr_q       <= '0;
      cur_ch_q    <= '0;
      cur_scan_q  <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (launch_d) begin
        state_q    <= FRAME;
        ncs_q      <= 1'b0;
        busy_q     <= 1'b1;
        sclk_q     <= 1'b0;
        dout_q     <= cmd_word_d[CMD_W-1];
        cmd_q      <= cmd_word_d;
        bit_q      <= '0;
        gap_q      <= '0;
        cur_ch_q   <= req_ch_d;
        cur_scan_q <= req_scan_d;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
            ncs_q  <= 1'b1;
            sclk_q <= 1'b0;
            dout_q <= 1'b0;
          end
          FRAME: begin
            if (tick) begin
              if (!sclk_q) begin
                // only the final RES_BITS shifts survive, so command-phase bits fall out
                sclk_q <= 1'b1;
                res_q  <= {res_q[RES_BITS-2:0], spi.dinAdc};
              end else begin
                sclk_q <= 1'b0;
                cmd_q  <= cmd_q << 1;
                dout_q <= cmd_q[CMD_W-2];
                bit_q  <= bit_q + BIT_W'(1);
                if (bit_q == LAST_BIT) begin
                  state_q     <= GAP;
                  ncs_q       <= 1'b1;
                  dout_q      <= 1'b0;
                  valid_q     <= 1'b1;
                  sample_q    <= res_q;
                  sample_ch_q <= cur_ch_q;
                  gap_q       <= '0;
                  if (cur_scan_q) begin
                    ptr_q <= (ptr_q == LAST_CH) ? '0 : ptr_q + CH_ADDR_W'(1);
                  end
                end
              end
            end
          end
          GAP: begin
            if (gap_q == LAST_GAP) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi.sclkAdc = sclk_q;
  assign spi.doutAdc = dout_q;
  assign spi.ncsAdc  = ncs_q;
  assign sample      = sample_q;
  assign sample_ch   = sample_ch_q;
  assign valid       = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Directed bench: three scanner instances (8-channel, 4-channel, DIFF/12-bit/CLK_DIV=2)
// each talking to a behavioural MCP300x model that decodes the channel from the command.
module tb_adc_spi_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_r [3];
  logic       scan_r  [3];
  logic [2:0] sel_r   [3];

  logic [9:0]  sample_a, sample_b;
  logic [11:0] sample_c;
  logic [2:0]  sample_ch_w [3];
  logic        valid_w [3];
  logic        busy_w  [3];
  logic [15:0] sample_w [3];

  logic       sclk_w [3];
  logic       dout_w [3];
  logic       ncs_w  [3];
  logic       din_v  [3];

  int checks = 0;
  int errors = 0;

  adc_spi_scanner_if ifa ();
  adc_spi_scanner_if ifb ();
  adc_spi_scanner_if ifc ();

  adc_spi_scanner #(.CHANNELS(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_r[0]), .scan(scan_r[0]), .chan_sel(sel_r[0]),
    .spi(ifa), .sample(sample_a), .sample_ch(sample_ch_w[0]), .valid(valid_w[0]), .busy(busy_w[0]));

  adc_spi_scanner #(.CHANNELS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_r[1]), .scan(scan_r[1]), .chan_sel(sel_r[1]),
    .spi(ifb), .sample(sample_b), .sample_ch(sample_ch_w[1]), .valid(valid_w[1]), .busy(busy_w[1]));

  adc_spi_scanner #(.CHANNELS(4), .RES_BITS(12), .CLK_DIV(2), .DIFF(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_r[2]), .scan(scan_r[2]), .chan_sel(sel_r[2]),
    .spi(ifc), .sample(sample_c), .sample_ch(sample_ch_w[2]), .valid(valid_w[2]), .busy(busy_w[2]));

  assign sample_w[0] = {6'd0, sample_a};
  assign sample_w[1] = {6'd0, sample_b};
  assign sample_w[2] = {4'd0, sample_c};
  assign sclk_w[0] = ifa.sclkAdc;  assign dout_w[0] = ifa.doutAdc;  assign ncs_w[0] = ifa.ncsAdc;
  assign sclk_w[1] = ifb.sclkAdc;  assign dout_w[1] = ifb.doutAdc;  assign ncs_w[1] = ifb.ncsAdc;
  assign sclk_w[2] = ifc.sclkAdc;  assign dout_w[2] = ifc.doutAdc;  assign ncs_w[2] = ifc.ncsAdc;
  assign ifa.dinAdc = din_v[0];
  assign ifb.dinAdc = din_v[1];
  assign ifc.dinAdc = din_v[2];

  // ADC model state: completed SCLK periods and the channel address shifted in
  int         k_m    [3];
  logic [2:0] addr_m [3];
  logic       prev_m [3];

  function automatic logic model_bit(input int idx, input int k, input logic [2:0] addr);
    int          res;
    int          j;
    logic [15:0] val;
    res = (idx == 2) ? 12 : 10;
    if (idx == 0)      val = 16'h02A5;
    else if (idx == 1) val = 16'h0100 + {13'd0, addr};
    else               val = 16'h0FFF;
    j = k - 7;
    if (j >= 0 && j < res) return val[res-1-j];
    else                   return 1'b0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ncs_w[i] !== 1'b0) begin
        k_m[i]    <= 0;
        addr_m[i] <= 3'd0;
      end else begin
        if (sclk_w[i] && !prev_m[i] && k_m[i] >= 2 && k_m[i] < 5)
          addr_m[i] <= {addr_m[i][1:0], dout_w[i]};
        if (!sclk_w[i] && prev_m[i])
          k_m[i] <= k_m[i] + 1;
      end
      prev_m[i] <= sclk_w[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) din_v[i] = model_bit(i, k_m[i], addr_m[i]);
  end

  // Runs one single conversion; cycle n=1 is the first cycle after the accepting edge.
  task automatic run_frame(input int idx, input logic [2:0] ch,
                           output int n_valid, output logic [15:0] smp, output logic [2:0] sch,
                           output int rises, output logic [4:0] cmd5, output int n_busy_low,
                           output int glitches, output logic ncs1, output logic busy1);
    logic prev_s;
    logic prev_d;
    n_valid = 0; smp = 16'd0; sch = 3'd0; rises = 0; cmd5 = 5'd0;
    n_busy_low = 0; glitches = 0; ncs1 = 1'b1; busy1 = 1'b0;
    prev_s = 1'b0; prev_d = 1'b0;
    sel_r[idx] = ch;
    start_r[idx] = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start_r[idx] = 1'b0;
        ncs1  = ncs_w[idx];
        busy1 = busy_w[idx];
      end else if (sclk_w[idx] && (dout_w[idx] !== prev_d)) begin
        glitches++;
      end
      prev_d = dout_w[idx];
      if (sclk_w[idx] && !prev_s) begin
        if (rises < 5) cmd5 = {cmd5[3:0], dout_w[idx]};
        rises++;
      end
      prev_s = sclk_w[idx];
      if (valid_w[idx] && n_valid == 0) begin
        n_valid = n;
        smp = sample_w[idx];
        sch = sample_ch_w[idx];
      end
      if (!busy_w[idx] && n > 1 && n_busy_low == 0) n_busy_low = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0; scan_r[i] = 1'b0; sel_r[i] = 3'd0;
    end
    repeat (3) @(negedge clk);
    checks++; if (ifb.ncsAdc !== 1'b1)  begin errors++; $display("FAIL reset_ncs got %0b want 1", ifb.ncsAdc); end
    checks++; if (ifb.sclkAdc !== 1'b0) begin errors++; $display("FAIL reset_sclk got %0b want 0", ifb.sclkAdc); end
    checks++; if (ifb.doutAdc !== 1'b0) begin errors++; $display("FAIL reset_dout got %0b want 0", ifb.doutAdc); end
    checks++; if (sample_b !== 10'd0)   begin errors++; $display("FAIL reset_sample got %0h want 0", sample_b); end
    checks++; if (sample_ch_w[1] !== 3'd0) begin errors++; $display("FAIL reset_sample_ch got %0d want 0", sample_ch_w[1]); end
    checks++; if (valid_w[1] !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b want 0", valid_w[1]); end
    checks++; if (busy_w[1] !== 1'b0)   begin errors++; $display("FAIL reset_busy got %0b want 0", busy_w[1]); end
    checks++;
    if (ifa.ncsAdc !== 1'b1 || ifc.ncsAdc !== 1'b1 || busy_w[0] !== 1'b0 || busy_w[2] !== 1'b0) begin
      errors++; $display("FAIL reset_other_duts ncs_a %0b ncs_c %0b busy_a %0b busy_c %0b want 1 1 0 0",
                         ifa.ncsAdc, ifc.ncsAdc, busy_w[0], busy_w[2]);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic prev_s;
    int   rises;
    int   vcount;
    prev_s = 1'b0; rises = 0; vcount = 0;
    sel_r[1] = 3'd3;
    start_r[1] = 1'b1;
    for (int n = 1; n <= 300 && rises < 10; n++) begin
      @(negedge clk);
      start_r[1] = 1'b0;
      if (ifb.sclkAdc && !prev_s) rises++;
      prev_s = ifb.sclkAdc;
    end
    checks++; if (rises != 10) begin errors++; $display("FAIL rstmid_reach_sclk9 got %0d rises want 10", rises); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ifb.ncsAdc !== 1'b1)  begin errors++; $display("FAIL rstmid_ncs got %0b want 1", ifb.ncsAdc); end
    checks++; if (ifb.sclkAdc !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %0b want 0", ifb.sclkAdc); end
    checks++; if (sample_b !== 10'd0)   begin errors++; $display("FAIL rstmid_sample got %0h want 0", sample_b); end
    checks++; if (valid_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid_busy got %0b %0b want 0 0", valid_w[1], busy_w[1]);
    end
    reset = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (valid_w[1]) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d want 0", vcount); end
  endtask

  task automatic test_single();
    int n_valid, rises, n_busy_low, glitches;
    logic [15:0] smp; logic [2:0] sch; logic [4:0] cmd5; logic ncs1, busy1;
    run_frame(0, 3'd5, n_valid, smp, sch, rises, cmd5, n_busy_low, glitches, ncs1, busy1);
    checks++; if (ncs1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL single_cycle1 ncs %0b busy %0b want 0 1", ncs1, busy1); end
    checks++; if (cmd5 !== 5'b11101) begin errors++; $display("FAIL single_cmd got %b want 11101", cmd5); end
    checks++; if (rises != 17)       begin errors++; $display("FAIL single_sclk_count got %0d want 17", rises); end
    checks++; if (n_valid != 137)    begin errors++; $display("FAIL single_valid_cycle got %0d want 137", n_valid); end
    checks++; if (smp !== 16'h02A5)  begin errors++; $display("FAIL single_sample got %0h want 2a5", smp); end
    checks++; if (sch !== 3'd5)      begin errors++; $display("FAIL single_sample_ch got %0d want 5", sch); end
    checks++; if (n_busy_low != 145) begin errors++; $display("FAIL single_busy_fall got %0d want 145", n_busy_low); end
    checks++; if (glitches != 0)     begin errors++; $display("FAIL single_dout_while_high got %0d want 0", glitches); end
  endtask

  task automatic test_drop_out_of_range();
    int bad;
    bad = 0;
    sel_r[1] = 3'd6;
    start_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ifb.ncsAdc !== 1'b1 || busy_w[1] !== 1'b0 || valid_w[1] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_quiet got %0d active cycles want 0", bad); end
  endtask

  task automatic test_start_while_busy();
    int vcount;
    logic [15:0] smp; logic [2:0] sch;
    vcount = 0; smp = 16'd0; sch = 3'd0;
    sel_r[1] = 3'd1;
    start_r[1] = 1'b1;
    for (int n = 1; n <= 330; n++) begin
      @(negedge clk);
      if (n == 1)  start_r[1] = 1'b0;
      if (n == 30) begin sel_r[1] = 3'd2; start_r[1] = 1'b1; end
      if (n == 31) start_r[1] = 1'b0;
      if (valid_w[1]) begin vcount++; smp = sample_w[1]; sch = sample_ch_w[1]; end
    end
    checks++; if (vcount != 1)      begin errors++; $display("FAIL busy_valid_count got %0d want 1", vcount); end
    checks++; if (sch !== 3'd1)     begin errors++; $display("FAIL busy_sample_ch got %0d want 1", sch); end
    checks++; if (smp !== 16'h0101) begin errors++; $display("FAIL busy_sample got %0h want 101", smp); end
  endtask

  task automatic test_scan();
    int          vn [5];
    logic [2:0]  vch [5];
    logic [15:0] vs [5];
    int got, run, min_gap, extra;
    logic seen_low;
    logic [2:0] exp_ch;
    got = 0; run = 0; min_gap = 1000; extra = 0; seen_low = 1'b0;
    scan_r[1] = 1'b1;
    for (int n = 1; n <= 1000 && got < 5; n++) begin
      @(negedge clk);
      if (ifb.ncsAdc) run++;
      else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        run = 0; seen_low = 1'b1;
      end
      if (valid_w[1]) begin
        vn[got] = n; vch[got] = sample_ch_w[1]; vs[got] = sample_w[1]; got++;
        if (got == 5) scan_r[1] = 1'b0;
      end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL scan_frames got %0d want 5", got); end
    for (int i = 0; i < got; i++) begin
      exp_ch = (i == 4) ? 3'd0 : 3'(i);
      checks++; if (vch[i] !== exp_ch) begin errors++; $display("FAIL scan_ch%0d got %0d want %0d", i, vch[i], exp_ch); end
      checks++; if (vs[i] !== (16'h0100 + {13'd0, exp_ch})) begin
        errors++; $display("FAIL scan_sample%0d got %0h want %0h", i, vs[i], 16'h0100 + {13'd0, exp_ch});
      end
      if (i > 0) begin
        checks++; if (vn[i] - vn[i-1] != 144) begin errors++; $display("FAIL scan_period%0d got %0d want 144", i, vn[i] - vn[i-1]); end
      end
    end
    checks++; if (min_gap < 8) begin errors++; $display("FAIL scan_cs_gap got %0d want >= 8", min_gap); end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (valid_w[1]) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL scan_stop got %0d extra frames want 0", extra); end
  endtask

  task automatic test_diff_wide();
    int n_valid, rises, n_busy_low, glitches;
    logic [15:0] smp; logic [2:0] sch; logic [4:0] cmd5; logic ncs1, busy1;
    run_frame(2, 3'd2, n_valid, smp, sch, rises, cmd5, n_busy_low, glitches, ncs1, busy1);
    checks++; if (cmd5 !== 5'b10010) begin errors++; $display("FAIL diff_cmd got %b want 10010", cmd5); end
    checks++; if (rises != 19)       begin errors++; $display("FAIL diff_sclk_count got %0d want 19", rises); end
    checks++; if (n_valid != 77)     begin errors++; $display("FAIL diff_valid_cycle got %0d want 77", n_valid); end
    checks++; if (smp !== 16'h0FFF)  begin errors++; $display("FAIL diff_sample got %0h want fff", smp); end
    checks++; if (sch !== 3'd2)      begin errors++; $display("FAIL diff_sample_ch got %0d want 2", sch); end
    checks++; if (n_busy_low != 85)  begin errors++; $display("FAIL diff_busy_fall got %0d want 85", n_busy_low); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_single();
    test_drop_out_of_range();
    test_start_while_busy();
    test_scan();
    test_diff_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
